elastic_rr_merge_dataless: RTL and testbench
============================================

Name: elastic_rr_merge_dataless

Overview:
Round-robin merge of NUM_INPUTS dataless elastic channels into one output channel, buffered by an internal index FIFO of NUM_SLOTS entries. Each accepted input token is stored as the index of the requester that sent it, and `outs_index` replays arrival order to downstream consumers. The block sits in front of shared dataless resources, such as a shared control token path or a shared unit's issue port, where the downstream side must know which requester a token came from.

Parameters:
NUM_INPUTS, 2, number of requester channels; legal range >=2.
NUM_SLOTS, 4, depth of the index FIFO; legal range >=2; need not be a power of two.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
ins_valid  input  NUM_INPUTS  per-requester valid.
ins_ready  output  NUM_INPUTS  per-requester ready; at most one bit high per cycle.
outs_valid  output  1  head token present.
outs_ready  input  1  downstream accepts head token.
outs_index  output  IDX_W  requester index of head token; IDX_W = max(1, clog2(NUM_INPUTS)).

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0, head=0, tail=0, full=0, empty=1.
  - Outputs: outs_valid=0, outs_index=0.
  - ins_ready reflects grant logic only: during and after reset, ins_ready[i]=1 only if ins_valid[i] is high and i is the winner.
  - Reset mid-operation discards all stored tokens immediately; no token completes in the reset cycle.
- Arbitration (combinational):
  - winner = first i with ins_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... cyclically mod NUM_INPUTS.
  - If no ins_valid bit is set, there is no winner and ins_ready is all zeros.
- Space and handshakes:
  - space = ~full | outs_ready.
  - ins_ready[winner] = space; every other ins_ready bit is 0.
  - push = a winner exists & space.
  - pop = outs_ready & ~empty.
  - outs_valid = ~empty; outs_index = mem[head].
- Pointer update on push:
  - mem[tail] <= winner.
  - tail <= (tail==NUM_SLOTS-1) ? 0 : tail+1.
  - rr_ptr <= (winner==NUM_INPUTS-1) ? 0 : winner+1.
  - Without a push, rr_ptr holds.
- Pointer update on pop: head wraps the same way as tail.
- Full/empty flags:
  - push only: empty<=0; full<=1 if next tail == head.
  - pop only: full<=0; empty<=1 if next head == tail.
  - push and pop together: flags unchanged.
  - push and pop when full: legal. The pop frees the slot, the new token is written, and full stays 1.
- Latency: minimum 1 cycle from input handshake to outs_valid. There is no combinational path from ins_valid to outs_valid (no bypass when empty).
- Throughput: one token per cycle sustained while outs_ready=1.
- Fairness: a requester holding valid is served within NUM_INPUTS grants.
- Protocol: inputs must hold valid until ready. Winner changes are allowed only in cycles without a handshake.

Optional Feature:
- Macro: ELASTIC_RR_MERGE_OCCUPANCY_EN.
- Defined: adds output port `occupancy`, width clog2(NUM_SLOTS+1).
  - Registered count of stored tokens; reset 0.
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Equals NUM_SLOTS exactly when full=1 and 0 exactly when empty=1.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - function clog2_min1(n), returning max(1, clog2(n)), used for IDX_W and pointer widths;
  - function wrap_inc(value, limit), the explicit compare-and-wrap increment used by head, tail and rr_ptr.
- One natural sub-module, elastic_fifo_index: the index FIFO, parameterised by DATA_W and NUM_SLOTS.
  - It contains head, tail, full, empty and the memory.
  - It uses the same ready = ~full | outs_ready rule.
- The arbiter (winner and rr_ptr) stays in the top level.

Test Plan:
1. Reset release, all ins_valid=0 -> outs_valid=0, ins_ready=00, outs_index=0; with the occupancy macro, occupancy=0.
2. NUM_INPUTS=2, both inputs held valid, outs_ready=1 -> grants alternate 0,1,0,1; outs_index sequence 0,1,0,1 each one cycle later; one token per cycle.
3. NUM_SLOTS=4, outs_ready=0, input 1 alone valid -> 4 pushes, then full=1 and ins_ready=00; raising outs_ready gives push and pop in the same cycle, full stays 1.
4. NUM_SLOTS=3 (not a power of two), 7 push-then-pop rounds -> head and tail wrap 2->0 correctly; outs_index order matches push order.
5. NUM_INPUTS=3, rr_ptr=2, ins_valid=011 -> winner=0 and the next rr_ptr=1; after that, with ins_valid=110 the winner is 1.
6. rst asserted with 2 stored tokens while outs_ready=1 -> outs_valid=0 immediately (asynchronous); after release the queue is empty and the first new token appears 1 cycle after its handshake.

Source files
------------

// File: rtl/elastic_rr_merge_dataless_pkg.sv
//------------------------------------------------------------------------------
// Module   : elastic_rr_merge_dataless_pkg
// Purpose  : Shared width and wrap-increment helpers for the dataless RR merge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package elastic_rr_merge_dataless_pkg;

   // Width needed to encode n distinct values, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int wrap_inc(input int value, input int limit);
      return (value == limit - 1) ? 0 : value + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/elastic_fifo_index.sv
//------------------------------------------------------------------------------
// Module   : elastic_fifo_index
// Purpose  : Elastic FIFO of requester indices; optional occupancy counter under
//            ELASTIC_RR_MERGE_OCCUPANCY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module elastic_fifo_index
   import elastic_rr_merge_dataless_pkg::*;
#(
   parameter int DATA_W    = 1,
   parameter int NUM_SLOTS = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [DATA_W-1:0]                       in_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [DATA_W-1:0]                       out_data
`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
   ,output logic [clog2_min1(NUM_SLOTS+1)-1:0]     occupancy
`endif
);

   localparam int PTR_W = clog2_min1(NUM_SLOTS);

   logic [DATA_W-1:0] r_mem [NUM_SLOTS];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic              r_full;
   logic              r_empty;
   logic [PTR_W-1:0]  w_head_nxt;
   logic [PTR_W-1:0]  w_tail_nxt;
   logic              w_push;
   logic              w_pop;

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign in_ready   = ~r_full | out_ready;
   assign w_push     = in_valid & in_ready;
   assign w_pop      = out_ready & ~r_empty;
   assign out_valid  = ~r_empty;
   assign out_data   = r_mem[r_head];
   assign w_head_nxt = PTR_W'(wrap_inc(int'(r_head), NUM_SLOTS));
   assign w_tail_nxt = PTR_W'(wrap_inc(int'(r_tail), NUM_SLOTS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= in_data;
            r_tail        <= w_tail_nxt;
         end
         if (w_pop) begin
            r_head <= w_head_nxt;
         end
         if (w_push && !w_pop) begin
            r_empty <= 1'b0;
            r_full  <= (w_tail_nxt == r_head);
         end else if (w_pop && !w_push) begin
            r_full  <= 1'b0;
            r_empty <= (w_head_nxt == r_tail);
         end
      end
   end

`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
   logic [clog2_min1(NUM_SLOTS+1)-1:0] r_occupancy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occupancy <= '0;
      end else if (w_push && !w_pop) begin
         r_occupancy <= r_occupancy + 1'b1;
      end else if (w_pop && !w_push) begin
         r_occupancy <= r_occupancy - 1'b1;
      end
   end

   assign occupancy = r_occupancy;
`endif

endmodule

`default_nettype wire

// File: rtl/elastic_rr_merge_dataless.sv
//------------------------------------------------------------------------------
// Module   : elastic_rr_merge_dataless
// Purpose  : Round-robin merge of dataless channels into an index FIFO that
//            replays requester order. ELASTIC_RR_MERGE_OCCUPANCY_EN adds occupancy.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module elastic_rr_merge_dataless
   import elastic_rr_merge_dataless_pkg::*;
#(
   parameter  int NUM_INPUTS = 2,
   parameter  int NUM_SLOTS  = 4,
   localparam int IDX_W      = clog2_min1(NUM_INPUTS)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_INPUTS-1:0]                   ins_valid,
   output logic [NUM_INPUTS-1:0]                   ins_ready,
   output logic                                    outs_valid,
   input  logic                                    outs_ready,
   output logic [IDX_W-1:0]                        outs_index
`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
   ,output logic [clog2_min1(NUM_SLOTS+1)-1:0]     occupancy
`endif
);

   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] w_winner;
   logic [IDX_W-1:0] w_cand;
   logic             w_have_winner;
   logic             w_space;

   function automatic int rot_idx(input int base, input int offset);
      int s;
      s = base + offset;
      return (s >= NUM_INPUTS) ? s - NUM_INPUTS : s;
   endfunction

   // Scan from the farthest offset down so the closest requester to rr_ptr wins.
   always_comb begin
      w_winner      = '0;
      w_have_winner = 1'b0;
      w_cand        = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         w_cand = IDX_W'(rot_idx(int'(r_rr_ptr), k));
         if (ins_valid[w_cand]) begin
            w_winner      = w_cand;
            w_have_winner = 1'b1;
         end
      end
   end

   always_comb begin
      ins_ready = '0;
      if (w_have_winner) begin
         ins_ready[w_winner] = w_space;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_have_winner && w_space) begin
         r_rr_ptr <= IDX_W'(wrap_inc(int'(w_winner), NUM_INPUTS));
      end
   end

   elastic_fifo_index #(
      .DATA_W    (IDX_W),
      .NUM_SLOTS (NUM_SLOTS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_have_winner),
      .in_ready  (w_space),
      .in_data   (w_winner),
      .out_valid (outs_valid),
      .out_ready (outs_ready),
`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
      .out_data  (outs_index),
      .occupancy (occupancy)
`else
      .out_data  (outs_index)
`endif
   );

endmodule

`default_nettype wire

// File: tb/tb_elastic_rr_merge_dataless.sv
//------------------------------------------------------------------------------
// Module   : tb_elastic_rr_merge_dataless
// Purpose  : Self-checking bench for elastic_rr_merge_dataless (3 inputs, 3 slots).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_elastic_rr_merge_dataless;

   localparam int N_IN = 3;
   localparam int N_SL = 3;
   localparam int IW   = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_IN-1:0] ins_valid = '0;
   logic [N_IN-1:0] ins_ready;
   logic            outs_valid;
   logic            outs_ready = 1'b0;
   logic [IW-1:0]   outs_index;
`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
   logic [1:0]      occupancy;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   elastic_rr_merge_dataless #(
      .NUM_INPUTS (N_IN),
      .NUM_SLOTS  (N_SL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
      .outs_index (outs_index),
      .occupancy  (occupancy)
`else
      .outs_index (outs_index)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of requester indices plus a round-robin pointer.
   int q[$];
   int rr = 0;

   initial begin
      int  win;
      bit  space, push, pop;
      logic [N_IN-1:0] exp_rdy;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            rr = 0;
         end
         win = -1;
         for (int k = 0; k < N_IN; k++) begin
            if (win < 0 && ins_valid[(rr + k) % N_IN]) win = (rr + k) % N_IN;
         end
         space   = (q.size() < N_SL) || outs_ready;
         exp_rdy = '0;
         if (win >= 0 && space) exp_rdy[win] = 1'b1;
         chk("model_ins_ready", 32'(ins_ready), 32'(exp_rdy));
         chk("model_outs_valid", 32'(outs_valid), 32'(q.size() > 0));
         if (q.size() > 0) chk("model_outs_index", 32'(outs_index), 32'(q[0]));
`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
         chk("model_occupancy", 32'(occupancy), 32'(q.size()));
`endif
         push = (win >= 0) && space;
         pop  = outs_ready && (q.size() > 0);
         @(posedge clk);
         if (rst) begin
            q.delete();
            rr = 0;
         end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
               q.push_back(win);
               rr = (win + 1) % N_IN;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N_IN-1:0] hs;
      int pr;

      // Grant logic is live during reset while storage stays empty.
      ins_valid = 3'b010;
      @(negedge clk);
      chk("reset_grant", 32'(ins_ready), 32'h2);
      chk("reset_outs_valid", 32'(outs_valid), 32'h0);
      step();
      ins_valid = '0;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("release_outs_valid", 32'(outs_valid), 32'h0);
      chk("release_ins_ready", 32'(ins_ready), 32'h0);
      chk("release_outs_index", 32'(outs_index), 32'h0);
`ifdef ELASTIC_RR_MERGE_OCCUPANCY_EN
      chk("release_occupancy", 32'(occupancy), 32'h0);
`endif

      // All inputs held valid: grants rotate, one token per cycle.
      step();
      ins_valid  = 3'b111;
      outs_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rotate_grant", 32'(ins_ready), 32'(1 << (c % 3)));
         if (c > 0) begin
            chk("rotate_outs_valid", 32'(outs_valid), 32'h1);
            chk("rotate_outs_index", 32'(outs_index), 32'((c - 1) % 3));
         end
         step();
      end
      ins_valid = '0;
      repeat (3) step();

      // Pointer skips to the next valid requester after the last winner.
      ins_valid = 3'b010;
      @(negedge clk);
      chk("rr_first", 32'(ins_ready), 32'h2);
      step();
      ins_valid = 3'b011;
      @(negedge clk);
      chk("rr_wrap_winner0", 32'(ins_ready), 32'h1);
      step();
      ins_valid = 3'b110;
      @(negedge clk);
      chk("rr_next_winner1", 32'(ins_ready), 32'h2);
      step();
      ins_valid = '0;
      repeat (4) step();

      // Fill to full with a stalled output, then push and pop while full.
      outs_ready = 1'b0;
      ins_valid  = 3'b010;
      for (int c = 0; c < N_SL; c++) begin
         @(negedge clk);
         chk("fill_ready", 32'(ins_ready), 32'h2);
         step();
      end
      @(negedge clk);
      chk("full_ready", 32'(ins_ready), 32'h0);
      chk("full_outs_valid", 32'(outs_valid), 32'h1);
      chk("full_outs_index", 32'(outs_index), 32'h1);
      step();
      outs_ready = 1'b1;
      @(negedge clk);
      chk("full_pushpop_ready", 32'(ins_ready), 32'h2);
      step();
      outs_ready = 1'b0;
      @(negedge clk);
      chk("still_full_ready", 32'(ins_ready), 32'h0);
      step();
      outs_ready = 1'b1;
      step();
      ins_valid = '0;
      repeat (5) step();

      // Push-then-pop rounds walk both pointers across the 3-slot wrap.
      for (int r = 0; r < 7; r++) begin
         outs_ready = 1'b0;
         ins_valid  = N_IN'(1 << (r % 3));
         step();
         ins_valid  = '0;
         outs_ready = 1'b1;
         @(negedge clk);
         chk("wrap_outs_valid", 32'(outs_valid), 32'h1);
         chk("wrap_outs_index", 32'(outs_index), 32'(r % 3));
         step();
      end

      // Asynchronous reset drops stored tokens immediately.
      outs_ready = 1'b0;
      ins_valid  = 3'b010;
      repeat (2) step();
      ins_valid  = '0;
      outs_ready = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset_outs_valid", 32'(outs_valid), 32'h0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_empty", 32'(outs_valid), 32'h0);
      step();
      ins_valid = 3'b100;
      @(negedge clk);
      chk("post_reset_grant", 32'(ins_ready), 32'h4);
      chk("no_bypass", 32'(outs_valid), 32'h0);
      step();
      ins_valid = '0;
      @(negedge clk);
      chk("post_reset_latency_valid", 32'(outs_valid), 32'h1);
      chk("post_reset_latency_index", 32'(outs_index), 32'h2);
      step();

      // Randomized traffic with valids held until accepted.
      for (int c = 0; c < 3000; c++) begin
         pr = (c < 1000) ? 30 : (c < 2000) ? 95 : 60;
         @(negedge clk);
         hs = ins_valid & ins_ready;
         step();
         if ($urandom_range(0, 599) == 0) begin
            rst       = 1'b1;
            ins_valid = '0;
            step();
            rst = 1'b0;
         end else begin
            for (int i = 0; i < N_IN; i++) begin
               if (!ins_valid[i] || hs[i]) ins_valid[i] = ($urandom_range(0, 99) < 40);
            end
         end
         outs_ready = ($urandom_range(0, 99) < pr);
      end

      ins_valid  = '0;
      outs_ready = 1'b1;
      repeat (6) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
